// File: rtl/repeated_pattern_tiler.sv
// Expands a programmed binary tile into sensor-width mask rows with per-tile-row stagger and optional inversion.
// Latency: row 0 is registered on the start edge; every later row is registered on the edge that accepts the one before it.
// Backpressure: rp_out_ack low (or clk_en low) freezes the current row and every frame counter.
module repeated_pattern_tiler #(
    parameter int SENSOR_W = 300,
    parameter int MAX_PW   = 8,
    parameter int MAX_PH   = 8,
    parameter int ROW_W    = 11,
    localparam int PW_W    = $clog2(MAX_PW + 1),
    localparam int PH_W    = $clog2(MAX_PH + 1),
    localparam int CS_W    = $clog2(MAX_PW),
    localparam int PAT_W   = MAX_PW * MAX_PH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic [PW_W-1:0]     pattern_w,
    input  logic [PH_W-1:0]     pattern_h,
    input  logic [PAT_W-1:0]    pattern,
    input  logic [CS_W-1:0]     col_shift,
    input  logic                invert,
    input  logic [ROW_W-1:0]    num_rows,
    input  logic                rp_start,
    input  logic                rp_out_ack,
    output logic [SENSOR_W-1:0] rp_mask_bit,
    output logic                rp_valid,
    output logic                rp_last,
    output logic                rp_busy,
    output logic                rp_done,
    output logic                rp_cfg_err
);
    localparam int SUM_W = PW_W + 1;
    localparam int OFF_W = $clog2(PAT_W + 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [PAT_W-1:0]    pat_q, pat_d;
    logic [PW_W-1:0]     pw_q, pw_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [CS_W-1:0]     cs_q, cs_d;
    logic                inv_q, inv_d;
    logic [PH_W-1:0]     pr_q, pr_d, pr_adv;
    logic [CS_W-1:0]     phase_q, phase_d, phase_adv;
    logic [ROW_W-1:0]    rows_left_q, rows_left_d;
    logic [SENSOR_W-1:0] mask_d;
    logic                valid_d, last_d, busy_d, done_d, cfg_err_d;
    logic [SUM_W-1:0]    phase_sum;

    logic [PAT_W-1:0]    sel_pat;
    logic [PW_W-1:0]     sel_pw;
    logic [PH_W-1:0]     sel_pr;
    logic [CS_W-1:0]     sel_phase;
    logic                sel_inv;
    logic [OFF_W-1:0]    row_off;
    logic [MAX_PW-1:0]   prow, rot;
    logic [SUM_W-1:0]    idx_sum;
    logic [CS_W-1:0]     col_idx;
    logic [SENSOR_W-1:0] row_dat;
    logic                cfg_ok;

    assign cfg_ok = (pattern_w != '0) && (pattern_w <= PW_W'(MAX_PW)) &&
                    (pattern_h != '0) && (pattern_h <= PH_W'(MAX_PH)) &&
                    (PW_W'(col_shift) < pattern_w) && (num_rows != '0);

    // Tile-row / phase position that the next accepted row will use
    always_comb begin
        pr_adv    = pr_q + PH_W'(1);
        phase_adv = phase_q;
        phase_sum = SUM_W'(phase_q) + SUM_W'(cs_q);
        if (phase_sum >= SUM_W'(pw_q)) phase_sum = phase_sum - SUM_W'(pw_q);
        if (pr_q == ph_q - PH_W'(1)) begin
            pr_adv    = '0;
            phase_adv = CS_W'(phase_sum);
        end
    end

    // A start builds row 0 from the live inputs; in RUN the latched copy is used
    always_comb begin
        if (state_q == IDLE) begin
            sel_pat   = pattern;
            sel_pw    = pattern_w;
            sel_inv   = invert;
            sel_pr    = '0;
            sel_phase = '0;
        end else begin
            sel_pat   = pat_q;
            sel_pw    = pw_q;
            sel_inv   = inv_q;
            sel_pr    = pr_adv;
            sel_phase = phase_adv;
        end
    end

    // rot[j] = prow[(j+phase) mod pw]; each column then picks rot[x mod pw] from a constant table
    always_comb begin
        row_off = OFF_W'(sel_pr) * OFF_W'(sel_pw);
        prow    = MAX_PW'(sel_pat >> row_off);
        rot     = '0;
        idx_sum = '0;
        col_idx = '0;
        row_dat = '0;
        for (int j = 0; j < MAX_PW; j++) begin
            idx_sum = SUM_W'(j) + SUM_W'(sel_phase);
            if (idx_sum >= SUM_W'(sel_pw)) idx_sum = idx_sum - SUM_W'(sel_pw);
            if (idx_sum < SUM_W'(MAX_PW)) rot[j] = prow[idx_sum[CS_W-1:0]];
        end
        for (int x = 0; x < SENSOR_W; x++) begin
            col_idx = '0;
            for (int k = 1; k <= MAX_PW; k++)
                if (sel_pw == PW_W'(k)) col_idx = CS_W'(x % k);
            row_dat[x] = rot[col_idx] ^ sel_inv;
        end
    end

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        pw_d        = pw_q;
        ph_d        = ph_q;
        cs_d        = cs_q;
        inv_d       = inv_q;
        pr_d        = pr_q;
        phase_d     = phase_q;
        rows_left_d = rows_left_q;
        mask_d      = rp_mask_bit;
        valid_d     = rp_valid;
        last_d      = rp_last;
        busy_d      = rp_busy;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rp_start) begin
                    if (cfg_ok) begin
                        state_d     = RUN;
                        pat_d       = pattern;
                        pw_d        = pattern_w;
                        ph_d        = pattern_h;
                        cs_d        = col_shift;
                        inv_d       = invert;
                        pr_d        = '0;
                        phase_d     = '0;
                        rows_left_d = num_rows;
                        mask_d      = row_dat;
                        valid_d     = 1'b1;
                        busy_d      = 1'b1;
                        last_d      = (num_rows == ROW_W'(1));
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rp_out_ack) begin
                    rows_left_d = rows_left_q - ROW_W'(1);
                    if (rows_left_q == ROW_W'(1)) begin
                        state_d = IDLE;
                        pr_d    = '0;
                        phase_d = '0;
                        mask_d  = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pr_d    = pr_adv;
                        phase_d = phase_adv;
                        mask_d  = row_dat;
                        last_d  = (rows_left_q == ROW_W'(2));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            pw_q        <= '0;
            ph_q        <= '0;
            cs_q        <= '0;
            inv_q       <= 1'b0;
            pr_q        <= '0;
            phase_q     <= '0;
            rows_left_q <= '0;
            rp_mask_bit <= '0;
            rp_valid    <= 1'b0;
            rp_last     <= 1'b0;
            rp_busy     <= 1'b0;
            rp_done     <= 1'b0;
            rp_cfg_err  <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            pw_q        <= pw_d;
            ph_q        <= ph_d;
            cs_q        <= cs_d;
            inv_q       <= inv_d;
            pr_q        <= pr_d;
            phase_q     <= phase_d;
            rows_left_q <= rows_left_d;
            rp_mask_bit <= mask_d;
            rp_valid    <= valid_d;
            rp_last     <= last_d;
            rp_busy     <= busy_d;
            rp_done     <= done_d;
            rp_cfg_err  <= cfg_err_d;
        end
    end
endmodule

// File: tb/tb_repeated_pattern_tiler.sv
// Randomized bench for repeated_pattern_tiler against a closed-form row model.
module tb_repeated_pattern_tiler;
    localparam int SENSOR_W = 300;
    localparam int PAT_W    = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clk_en = 1'b0;
    logic [3:0]          pattern_w = '0;
    logic [3:0]          pattern_h = '0;
    logic [PAT_W-1:0]    pattern = '0;
    logic [2:0]          col_shift = '0;
    logic                invert = 1'b0;
    logic [10:0]         num_rows = '0;
    logic                rp_start = 1'b0;
    logic                rp_out_ack = 1'b0;
    logic [SENSOR_W-1:0] rp_mask_bit;
    logic                rp_valid, rp_last, rp_busy, rp_done, rp_cfg_err;

    int total = 0;
    int bad = 0;

    repeated_pattern_tiler dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .pattern_w(pattern_w), .pattern_h(pattern_h), .pattern(pattern),
        .col_shift(col_shift), .invert(invert), .num_rows(num_rows),
        .rp_start(rp_start), .rp_out_ack(rp_out_ack),
        .rp_mask_bit(rp_mask_bit), .rp_valid(rp_valid), .rp_last(rp_last),
        .rp_busy(rp_busy), .rp_done(rp_done), .rp_cfg_err(rp_cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [SENSOR_W-1:0] got, input logic [SENSOR_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Row k of a frame: tile row k mod ph, phase advanced by cs once per completed tile height
    function automatic logic [SENSOR_W-1:0] model_row(input int pw, input int ph, input logic [PAT_W-1:0] pat,
                                                      input int cs, input bit inv, input int k);
        logic [SENSOR_W-1:0] r;
        int pr = k % ph;
        int phs = ((k / ph) * cs) % pw;
        for (int x = 0; x < SENSOR_W; x++)
            r[x] = pat[pr * pw + (x + phs) % pw] ^ inv;
        return r;
    endfunction

    // Called on a falling edge; returns on the falling edge where rp_done is visible
    task automatic run_frame(input int pw, input int ph, input logic [PAT_W-1:0] pat, input int cs, input bit inv,
                             input int n, input int ack_pct, input int en_pct, input int hold_k, input int hold_len);
        int k = 0;
        int cyc = 0;
        int held = 0;
        bit ack, en;
        pattern_w = 4'(pw); pattern_h = 4'(ph); pattern = pat; col_shift = 3'(cs);
        invert = inv; num_rows = 11'(n);
        rp_start = 1'b1; clk_en = 1'b1; rp_out_ack = 1'b0;
        @(negedge clk);
        rp_start = 1'b0;
        check_val("busy_after_start", rp_busy, 1);
        while (k < n && cyc < 20000) begin
            check_val("valid", rp_valid, 1);
            check_val("row", rp_mask_bit, model_row(pw, ph, pat, cs, inv, k));
            check_val("last", rp_last, k == n - 1);
            check_val("no_cfg_err_in_run", rp_cfg_err, 0);
            if (k == hold_k && held < hold_len) begin
                ack = 1'b0;
                held++;
            end else begin
                ack = $urandom_range(99) < ack_pct;
            end
            en = $urandom_range(99) < en_pct;
            rp_out_ack = ack;
            clk_en = en;
            pattern = {$urandom, $urandom};
            pattern_w = 4'($urandom);
            pattern_h = 4'($urandom);
            col_shift = 3'($urandom);
            invert = 1'($urandom);
            num_rows = 11'($urandom);
            rp_start = 1'($urandom);
            @(negedge clk);
            cyc++;
            if (ack && en) k++;
        end
        rp_start = 1'b0; rp_out_ack = 1'b0; clk_en = 1'b1;
        if (k < n) check_val("frame_timeout", k, n);
        check_val("done_pulse", rp_done, 1);
        check_val("valid_after_done", rp_valid, 0);
        check_val("busy_after_done", rp_busy, 0);
        check_val("last_after_done", rp_last, 0);
        if (ack_pct >= 100 && en_pct >= 100 && hold_len == 0) check_val("cycles_per_frame", cyc, n);
    endtask

    task automatic cfg_reject(input int pw, input int ph, input int cs, input int n);
        pattern_w = 4'(pw); pattern_h = 4'(ph); col_shift = 3'(cs); num_rows = 11'(n);
        rp_start = 1'b1; clk_en = 1'b1; rp_out_ack = 1'b0;
        @(negedge clk);
        rp_start = 1'b0;
        check_val("cfg_err_pulse", rp_cfg_err, 1);
        check_val("cfg_err_valid", rp_valid, 0);
        check_val("cfg_err_busy", rp_busy, 0);
        @(negedge clk);
        check_val("cfg_err_clear", rp_cfg_err, 0);
        check_val("cfg_err_valid2", rp_valid, 0);
    endtask

    initial begin
        logic [PAT_W-1:0] rpat;
        int pw, ph, cs;

        @(negedge clk);
        check_val("rst_mask", rp_mask_bit, '0);
        check_val("rst_valid", rp_valid, 0);
        check_val("rst_busy", rp_busy, 0);
        check_val("rst_flags", {rp_last, rp_done, rp_cfg_err}, 0);
        rst_n = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);

        run_frame(3, 3, 64'd335, 0, 1'b0, 100, 100, 100, -1, 0);
        run_frame(3, 1, 64'd1, 1, 1'b0, 4, 100, 100, -1, 0);
        run_frame(3, 3, 64'd335, 0, 1'b1, 10, 100, 100, 1, 5);

        cfg_reject(0, 3, 0, 5);
        cfg_reject(3, 3, 3, 5);
        cfg_reject(9, 3, 0, 5);
        cfg_reject(3, 0, 0, 5);
        cfg_reject(3, 3, 0, 0);

        run_frame(3, 3, 64'd335, 1, 1'b0, 20, 100, 50, -1, 0);

        // Abort a staggered frame at row 40, then restart it from row 0
        rpat = {$urandom, $urandom};
        pattern_w = 4'd3; pattern_h = 4'd2; pattern = rpat; col_shift = 3'd1;
        invert = 1'b0; num_rows = 11'd100;
        rp_start = 1'b1; clk_en = 1'b1; rp_out_ack = 1'b1;
        @(negedge clk);
        rp_start = 1'b0;
        repeat (40) @(negedge clk);
        check_val("pre_reset_row40", rp_mask_bit, model_row(3, 2, rpat, 1, 1'b0, 40));
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_mask", rp_mask_bit, '0);
        check_val("midrst_valid", rp_valid, 0);
        check_val("midrst_busy", rp_busy, 0);
        check_val("midrst_flags", {rp_last, rp_done, rp_cfg_err}, 0);
        @(negedge clk);
        check_val("midrst_no_done", rp_done, 0);
        rst_n = 1'b1;
        rp_out_ack = 1'b0;
        @(negedge clk);
        check_val("post_rst_idle", rp_valid, 0);
        run_frame(3, 2, rpat, 1, 1'b0, 10, 100, 100, -1, 0);

        for (int t = 0; t < 30; t++) begin
            pw = $urandom_range(1, 8);
            ph = $urandom_range(1, 8);
            cs = $urandom_range(0, pw - 1);
            rpat = {$urandom, $urandom};
            run_frame(pw, ph, rpat, cs, 1'($urandom), $urandom_range(1, 60),
                      $urandom_range(40, 100), $urandom_range(60, 100), -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/repeated_pattern_tiler.md
# repeated_pattern_tiler

Parametrised successor to the row-mask pattern generator. It takes a small binary tile of up to MAX_PW×MAX_PH bits and expands it into full sensor-width mask rows, one row per accepted handshake, for a programmed number of rows. It adds three things: a per-tile-row horizontal stagger, optional inversion, and downstream backpressure. It sits between the micro-processor configuration registers and the sensor mask driver.

## Interface
- SENSOR_W, 300, mask row width in bits
- MAX_PW, 8, maximum tile width
- MAX_PH, 8, maximum tile height
- ROW_W, 11, width of the row-count field (up to 2047 rows)
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- clk_en  in  1  clock enable; when 0 all state holds and inputs are ignored
- pattern_w  in  $clog2(MAX_PW+1)  tile width, legal range 1..MAX_PW
- pattern_h  in  $clog2(MAX_PH+1)  tile height, legal range 1..MAX_PH
- pattern  in  MAX_PW*MAX_PH  dense row-major tile: row r occupies bits [r*pattern_w +: pattern_w], LSB is column 0
- col_shift  in  $clog2(MAX_PW)  phase advance per completed tile height; must be < pattern_w
- invert  in  1  invert every output bit
- num_rows  in  ROW_W  number of rows to emit, must be ≥1
- rp_start  in  1  start request, sampled in IDLE only
- rp_out_ack  in  1  downstream accepts the current row
- rp_mask_bit  out  SENSOR_W  mask row; bit x is sensor column x
- rp_valid  out  1  rp_mask_bit holds a valid row
- rp_last  out  1  the current valid row is the final row
- rp_busy  out  1  a frame is in progress
- rp_done  out  1  one-cycle pulse after the final row is accepted
- rp_cfg_err  out  1  one-cycle pulse when a start is rejected

## Operation
- States: IDLE, RUN.
- **IDLE, start accepted:** rp_start=1 and clk_en=1 with a legal configuration.
  - Latch all configuration inputs.
  - Set pattern-row pr=0, phase=0, rows_left=num_rows.
  - Register row 0 into rp_mask_bit and go to RUN.
- **IDLE, start rejected:** the configuration is illegal (pattern_w∉1..MAX_PW, pattern_h∉1..MAX_PH, col_shift≥pattern_w, or num_rows=0).
  - Pulse rp_cfg_err for one cycle.
  - Stay in IDLE. rp_valid stays 0.
- **Row content for sensor column x:** bit = prow[(x+phase) mod pw] XOR invert, where prow = latched pattern row pr.
- **Advance on acceptance:** a row is accepted on an edge where rp_valid=1, rp_out_ack=1 and clk_en=1. On acceptance:
  - rows_left decrements.
  - pr increments. On pr wrap (pr=ph−1 → 0), phase = (phase+col_shift) mod pw.
  - The next row is registered on the same edge.
- **Final row:** when rows_left=1, rp_last=1 alongside rp_valid. When that row is accepted:
  - rp_valid=0, rp_last=0, rp_busy=0.
  - rp_done=1 for one cycle.
  - Go to IDLE.
- rp_start during RUN is ignored. Configuration input changes during RUN have no effect, because the latched copy is used.
- **Backpressure:** while rp_valid=1 and rp_out_ack=0, rp_mask_bit, rp_last, pr, phase and rows_left are stable.
- **clk_en=0:** no state or output register changes, and rp_out_ack is ignored. Pulses such as rp_done stay high until the next enabled edge.
- **Arithmetic:**
  - Use the unsigned widths listed above.
  - The phase sum never exceeds 2·MAX_PW−2, so reduce it with a single conditional subtract.
  - Column mod arithmetic is static per column; no divider is allowed.

## Timing
- **Reset (asynchronous):** every output is 0 (rp_mask_bit=0, rp_valid=0, rp_last=0, rp_busy=0, rp_done=0, rp_cfg_err=0). State is IDLE and all counters are 0. Reset mid-frame aborts the frame immediately, with no rp_done.
- **Start latency:** start accepted at edge E0 gives rp_valid=1 with row 0 and rp_busy=1 after E0.
- **Throughput:** one row per cycle when rp_out_ack is held at 1. N rows complete in N cycles after the first valid.
- **rp_cfg_err:** high for exactly the cycle following the rejecting edge.
- **rp_done:** high for the cycle following the final acceptance. A new rp_start is accepted in that same cycle.

## Test plan
- **Basic 3×3 tile.** SENSOR_W=300, pw=ph=3, pattern=335 (rows 111/001/101), col_shift=0, num_rows=100, ack=1. Required:
  - Row0 is all ones.
  - Row1 has bit x=1 iff x%3=0.
  - Row2 has bit x=1 iff x%3∈{0,2}.
  - Row3 equals row0.
  - Exactly 100 valid cycles, rp_last on row 99, one rp_done.
- **Stagger.** pw=3, ph=1, pattern=3'b001, col_shift=1, num_rows=4. Required:
  - Row0 has bit x=1 iff x%3=0.
  - Row1 has bit x=1 iff x%3=2.
  - Row2 has bit x=1 iff x%3=1.
  - Row3 equals row0.
- **Backpressure and invert.** invert=1; hold rp_out_ack=0 for 5 cycles on row 1. Required:
  - Row 1 is held stable and inverted.
  - Row 2 appears on the cycle after the ack edge.
  - Total row count is unchanged.
- **Config error.** pattern_w=0 with rp_start=1. Required: rp_cfg_err pulses for 1 cycle, rp_valid and rp_busy stay 0. Repeat with col_shift=3, pw=3: same response.
- **Reset mid-frame.** Assert rst_n=0 asynchronously at row 40 of 100. Required:
  - All outputs are 0 immediately and there is no rp_done.
  - A new start after release begins again at row 0, phase 0.
- **clk_en gating.** Deassert clk_en for 3 cycles while ack=1. Required: no rows are consumed, outputs are frozen, and the sequence resumes unchanged.
